// File: rtl/mc_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mc_control_unit (with mc_control_pkg)                        |
// | Description : Multi-cycle MIPS-subset control unit. Sequences FETCH,       |
// |               DECODE, EXEC, MEM and WB, decodes datapath selects from the  |
// |               latched instruction and stops in HALT on a halt opcode, an   |
// |               illegal encoding or a memory-wait timeout.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

package mc_control_pkg;
  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;
endpackage

module mc_control_unit
  import mc_control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CHECK_OF    = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] Instr,
  input  logic        ihit,
  input  logic        dhit,
  output logic [2:0]  jump_t,
  output logic [1:0]  RegDst_t,
  output logic [2:0]  ALUSrc_t,
  output aluop_t      ALUOP,
  output logic        RegWen,
  output logic        MemToReg,
  output logic        PcToReg,
  output logic        PCWen,
  output logic        iREN,
  output logic        dREN,
  output logic        dWEN,
  output logic        checkOF,
  output logic        halt,
  output logic        fault,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Counter only has to reach MEM_TIMEOUT-1; the timeout fires on that cycle.
  localparam int c_cntW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int c_toLast = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;

  localparam logic [5:0] c_opRtype = 6'h00;
  localparam logic [5:0] c_opJ     = 6'h02;
  localparam logic [5:0] c_opJal   = 6'h03;
  localparam logic [5:0] c_opBeq   = 6'h04;
  localparam logic [5:0] c_opBne   = 6'h05;
  localparam logic [5:0] c_opAddi  = 6'h08;
  localparam logic [5:0] c_opAddiu = 6'h09;
  localparam logic [5:0] c_opSlti  = 6'h0A;
  localparam logic [5:0] c_opSltiu = 6'h0B;
  localparam logic [5:0] c_opAndi  = 6'h0C;
  localparam logic [5:0] c_opOri   = 6'h0D;
  localparam logic [5:0] c_opXori  = 6'h0E;
  localparam logic [5:0] c_opLui   = 6'h0F;
  localparam logic [5:0] c_opLw    = 6'h23;
  localparam logic [5:0] c_opSw    = 6'h2B;
  localparam logic [5:0] c_opHalt  = 6'h3F;

  localparam logic [5:0] c_fnSll  = 6'h00;
  localparam logic [5:0] c_fnSrl  = 6'h02;
  localparam logic [5:0] c_fnJr   = 6'h08;
  localparam logic [5:0] c_fnAdd  = 6'h20;
  localparam logic [5:0] c_fnAddu = 6'h21;
  localparam logic [5:0] c_fnSub  = 6'h22;
  localparam logic [5:0] c_fnSubu = 6'h23;
  localparam logic [5:0] c_fnAnd  = 6'h24;
  localparam logic [5:0] c_fnOr   = 6'h25;
  localparam logic [5:0] c_fnXor  = 6'h26;
  localparam logic [5:0] c_fnNor  = 6'h27;
  localparam logic [5:0] c_fnSlt  = 6'h2A;
  localparam logic [5:0] c_fnSltu = 6'h2B;

  state_t            r_state;
  state_t            w_nextState;
  logic [31:0]       r_ir;
  logic [c_cntW-1:0] r_waitCnt;
  logic [c_cntW-1:0] w_nextWaitCnt;
  logic              r_active;
  logic              r_fault;
  logic              w_loadIr;
  logic              w_setFault;
  logic              w_timeUp;

  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic              w_legal;
  logic              w_isHalt;
  logic              w_isMem;
  logic              w_isLoad;
  logic              w_noWb;
  logic              w_ofCand;
  logic              w_unusedIrFields;

  assign w_opcode = r_ir[31:26];
  assign w_funct  = r_ir[5:0];
  // Register-number and shamt fields are consumed by the datapath, not here.
  assign w_unusedIrFields = ^r_ir[25:6];

  assign w_timeUp = (MEM_TIMEOUT > 0) && (r_waitCnt == c_cntW'(c_toLast));

  // Instruction decode: selects are a pure function of IR, so they stay put until the next fetch.
  always_comb begin
    jump_t   = 3'b000;
    RegDst_t = 2'b00;
    ALUSrc_t = 3'b000;
    ALUOP    = ALU_ADD;
    MemToReg = 1'b0;
    PcToReg  = 1'b0;
    w_ofCand = 1'b0;
    w_legal  = 1'b1;
    w_isHalt = 1'b0;
    w_isMem  = 1'b0;
    w_isLoad = 1'b0;
    w_noWb   = 1'b0;
    case (w_opcode)
      c_opRtype: begin
        case (w_funct)
          c_fnAdd:  begin ALUOP = ALU_ADD; w_ofCand = 1'b1; end
          c_fnAddu: ALUOP = ALU_ADD;
          c_fnSub:  begin ALUOP = ALU_SUB; w_ofCand = 1'b1; end
          c_fnSubu: ALUOP = ALU_SUB;
          c_fnAnd:  ALUOP = ALU_AND;
          c_fnOr:   ALUOP = ALU_OR;
          c_fnXor:  ALUOP = ALU_XOR;
          c_fnNor:  ALUOP = ALU_NOR;
          c_fnSlt:  ALUOP = ALU_SLT;
          c_fnSltu: ALUOP = ALU_SLTU;
          c_fnSll:  begin ALUOP = ALU_SLL; ALUSrc_t = 3'b100; end
          c_fnSrl:  begin ALUOP = ALU_SRL; ALUSrc_t = 3'b100; end
          c_fnJr:   begin jump_t = 3'b010; w_noWb = 1'b1; end
          default:  w_legal = 1'b0;
        endcase
      end
      c_opJ:     begin jump_t = 3'b001; w_noWb = 1'b1; end
      c_opJal:   begin jump_t = 3'b001; RegDst_t = 2'b10; PcToReg = 1'b1; end
      c_opBeq:   begin jump_t = 3'b011; ALUSrc_t = 3'b001; ALUOP = ALU_SUB; w_noWb = 1'b1; end
      c_opBne:   begin jump_t = 3'b100; ALUSrc_t = 3'b001; ALUOP = ALU_SUB; w_noWb = 1'b1; end
      c_opAddi:  begin RegDst_t = 2'b01; ALUSrc_t = 3'b001; ALUOP = ALU_ADD; w_ofCand = 1'b1; end
      c_opAddiu: begin RegDst_t = 2'b01; ALUSrc_t = 3'b001; ALUOP = ALU_ADD; end
      c_opSlti:  begin RegDst_t = 2'b01; ALUSrc_t = 3'b001; ALUOP = ALU_SLT; end
      c_opSltiu: begin RegDst_t = 2'b01; ALUSrc_t = 3'b001; ALUOP = ALU_SLTU; end
      c_opAndi:  begin RegDst_t = 2'b01; ALUSrc_t = 3'b010; ALUOP = ALU_AND; end
      c_opOri:   begin RegDst_t = 2'b01; ALUSrc_t = 3'b010; ALUOP = ALU_OR; end
      c_opXori:  begin RegDst_t = 2'b01; ALUSrc_t = 3'b010; ALUOP = ALU_XOR; end
      c_opLui:   begin RegDst_t = 2'b01; ALUSrc_t = 3'b011; ALUOP = ALU_OR; end
      c_opLw: begin
        RegDst_t = 2'b01;
        ALUSrc_t = 3'b001;
        ALUOP    = ALU_ADD;
        MemToReg = 1'b1;
        w_isMem  = 1'b1;
        w_isLoad = 1'b1;
      end
      c_opSw: begin
        ALUSrc_t = 3'b001;
        ALUOP    = ALU_ADD;
        w_isMem  = 1'b1;
      end
      c_opHalt:  w_isHalt = 1'b1;
      default:   w_legal = 1'b0;
    endcase
  end

  // Overflow checking can be compiled out entirely.
  generate
    if (CHECK_OF != 0) begin : g_checkOf
      assign checkOF = w_ofCand;
    end else begin : g_noCheckOf
      assign checkOF = 1'b0;
    end
  endgenerate

  // Next-state, wait-counter and enable generation.
  always_comb begin
    w_nextState   = r_state;
    w_nextWaitCnt = '0;
    w_loadIr      = 1'b0;
    w_setFault    = 1'b0;
    iREN          = 1'b0;
    dREN          = 1'b0;
    dWEN          = 1'b0;
    RegWen        = 1'b0;
    PCWen         = 1'b0;
    case (r_state)
      FETCH: begin
        // The first edge after reset release only arms the fetch.
        if (r_active) begin
          iREN = 1'b1;
          if (ihit) begin
            w_loadIr    = 1'b1;
            w_nextState = DECODE;
          end else if (w_timeUp) begin
            w_setFault  = 1'b1;
            w_nextState = HALT;
          end else begin
            w_nextWaitCnt = r_waitCnt + c_cntW'(1);
          end
        end
      end
      DECODE: begin
        if (w_isHalt) begin
          w_nextState = HALT;
        end else if (!w_legal) begin
          w_setFault  = 1'b1;
          w_nextState = HALT;
        end else begin
          w_nextState = EXEC;
        end
      end
      EXEC: begin
        if (w_isMem) begin
          w_nextState = MEM;
        end else if (w_noWb) begin
          PCWen       = 1'b1;
          w_nextState = FETCH;
        end else begin
          w_nextState = WB;
        end
      end
      MEM: begin
        dREN = w_isLoad;
        dWEN = !w_isLoad;
        if (dhit) begin
          if (w_isLoad) begin
            w_nextState = WB;
          end else begin
            PCWen       = 1'b1;
            w_nextState = FETCH;
          end
        end else if (w_timeUp) begin
          w_setFault  = 1'b1;
          w_nextState = HALT;
        end else begin
          w_nextWaitCnt = r_waitCnt + c_cntW'(1);
        end
      end
      WB: begin
        RegWen      = 1'b1;
        PCWen       = 1'b1;
        w_nextState = FETCH;
      end
      HALT: begin
        w_nextState = HALT;
      end
      default: begin
        w_nextState = FETCH;
      end
    endcase
  end

  // State, instruction and status registers; reset aborts any access in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= FETCH;
      r_ir      <= 32'd0;
      r_waitCnt <= '0;
      r_active  <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextWaitCnt;
      r_active  <= 1'b1;
      if (w_loadIr) begin
        r_ir <= Instr;
      end
      if (w_setFault) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign halt  = (r_state == HALT);
  assign fault = r_fault;
  assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mc_control_unit                                           |
// | Description : Directed self-checking bench for mc_control_unit.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mc_control_unit;
  import mc_control_pkg::*;

  localparam logic [31:0] c_add   = 32'h00221820;
  localparam logic [31:0] c_lw    = 32'h8C220004;
  localparam logic [31:0] c_sw    = 32'hAC220008;
  localparam logic [31:0] c_bne   = 32'h14220003;
  localparam logic [31:0] c_jal   = 32'h0C000010;
  localparam logic [31:0] c_halt  = 32'hFC000000;
  localparam logic [31:0] c_illeg = 32'hF8000000;

  logic CLK = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Default-parameter instance
  logic nRST = 1'b1, ihit = 1'b0, dhit = 1'b0;
  logic [31:0] Instr = 32'd0;
  logic [2:0] jump_t, ALUSrc_t, state;
  logic [1:0] RegDst_t;
  aluop_t ALUOP;
  logic RegWen, MemToReg, PcToReg, PCWen, iREN, dREN, dWEN, checkOF, halt, fault;

  // Short-timeout, no-overflow-check instance
  logic nRSTB = 1'b1, ihitB = 1'b0, dhitB = 1'b0;
  logic [31:0] InstrB = 32'd0;
  logic [2:0] jump_tB, ALUSrc_tB, stateB;
  logic [1:0] RegDst_tB;
  aluop_t ALUOPB;
  logic RegWenB, MemToRegB, PcToRegB, PCWenB, iRENB, dRENB, dWENB, checkOFB, haltB, faultB;

  mc_control_unit dut (
    .CLK(CLK), .nRST(nRST), .Instr(Instr), .ihit(ihit), .dhit(dhit),
    .jump_t(jump_t), .RegDst_t(RegDst_t), .ALUSrc_t(ALUSrc_t), .ALUOP(ALUOP),
    .RegWen(RegWen), .MemToReg(MemToReg), .PcToReg(PcToReg), .PCWen(PCWen),
    .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .checkOF(checkOF),
    .halt(halt), .fault(fault), .state(state)
  );

  mc_control_unit #(.MEM_TIMEOUT(4), .CHECK_OF(0)) dutB (
    .CLK(CLK), .nRST(nRSTB), .Instr(InstrB), .ihit(ihitB), .dhit(dhitB),
    .jump_t(jump_tB), .RegDst_t(RegDst_tB), .ALUSrc_t(ALUSrc_tB), .ALUOP(ALUOPB),
    .RegWen(RegWenB), .MemToReg(MemToRegB), .PcToReg(PcToRegB), .PCWen(PCWenB),
    .iREN(iRENB), .dREN(dRENB), .dWEN(dWENB), .checkOF(checkOFB),
    .halt(haltB), .fault(faultB), .state(stateB)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present an instruction in the current FETCH cycle and hit immediately -> DECODE.
  task automatic fetchNow(input logic [31:0] instr);
    Instr = instr;
    ihit  = 1'b1;
    step();
    ihit  = 1'b0;
  endtask

  // Full register-writing ALU instruction: FETCH, DECODE, EXEC, WB, FETCH.
  task automatic runAlu(input string tag, input logic [31:0] instr, input aluop_t op,
                        input logic [2:0] src, input logic [1:0] dst, input logic of);
    fetchNow(instr);
    check({tag, " dec state"}, 32'(state), 32'd1);
    check({tag, " aluop"}, 32'(ALUOP), 32'(op));
    check({tag, " alusrc"}, 32'(ALUSrc_t), 32'(src));
    check({tag, " regdst"}, 32'(RegDst_t), 32'(dst));
    check({tag, " checkOF"}, 32'(checkOF), 32'(of));
    step();
    check({tag, " exec state"}, 32'(state), 32'd2);
    step();
    check({tag, " wb state"}, 32'(state), 32'd4);
    check({tag, " wb en"}, {30'd0, RegWen, PCWen}, 32'd3);
    check({tag, " wb aluop held"}, 32'(ALUOP), 32'(op));
    step();
    check({tag, " back to fetch"}, 32'(state), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    #1 nRST = 1'b0; nRSTB = 1'b0;
    #2;
    check("rst state", 32'(state), 32'd0);
    check("rst enables", {27'd0, iREN, RegWen, PCWen, dREN, dWEN}, 32'd0);
    check("rst halt/fault", {30'd0, halt, fault}, 32'd0);
    @(posedge CLK); #1;
    check("rst iREN held low", 32'(iREN), 32'd0);
    nRST = 1'b1;
    step();
    check("first fetch iREN", 32'(iREN), 32'd1);

    // ADD with ihit on third FETCH cycle
    Instr = c_add;
    step();
    check("add fetch c2", {28'd0, state, iREN}, {28'd0, 3'd0, 1'b1});
    step();
    check("add fetch c3", 32'(state), 32'd0);
    ihit = 1'b1;
    step();
    ihit = 1'b0;
    check("add decode", 32'(state), 32'd1);
    check("add dec regwen", {30'd0, RegWen, iREN}, 32'd0);
    check("add dec aluop", 32'(ALUOP), 32'(ALU_ADD));
    step();
    check("add exec", {28'd0, state, PCWen}, {28'd0, 3'd2, 1'b0});
    step();
    check("add wb state", 32'(state), 32'd4);
    check("add wb en", {30'd0, RegWen, PCWen}, 32'd3);
    check("add wb regdst", 32'(RegDst_t), 32'd0);
    check("add wb aluop", 32'(ALUOP), 32'(ALU_ADD));
    check("add wb checkOF", 32'(checkOF), 32'd1);
    step();
    check("add refetch", {28'd0, state, iREN}, {28'd0, 3'd0, 1'b1});
    check("add wb one cycle", 32'(RegWen), 32'd0);

    // LW with dhit on fourth MEM cycle
    fetchNow(c_lw);
    check("lw memtoreg", 32'(MemToReg), 32'd1);
    check("lw alusrc", 32'(ALUSrc_t), 32'd1);
    check("lw checkOF", 32'(checkOF), 32'd0);
    step();
    step();
    check("lw mem", {28'd0, state, dREN}, {28'd0, 3'd3, 1'b1});
    check("lw no dwen", 32'(dWEN), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("lw mem hold", {28'd0, state, dREN}, {28'd0, 3'd3, 1'b1});
    end
    dhit = 1'b1;
    step();
    dhit = 1'b0;
    check("lw wb state", 32'(state), 32'd4);
    check("lw wb", {28'd0, RegWen, MemToReg, RegDst_t}, {28'd0, 1'b1, 1'b1, 2'b01});
    check("lw wb dren off", 32'(dREN), 32'd0);
    step();

    // BNE, with stray strobes during DECODE
    fetchNow(c_bne);
    check("bne jump", 32'(jump_t), 32'h4);
    check("bne aluop", 32'(ALUOP), 32'(ALU_SUB));
    Instr = c_lw; ihit = 1'b1; dhit = 1'b1;
    step();
    ihit = 1'b0; dhit = 1'b0;
    check("bne exec", {28'd0, state, PCWen}, {28'd0, 3'd2, 1'b1});
    check("bne ir kept", {28'd0, jump_t, MemToReg}, {28'd0, 3'b100, 1'b0});
    check("bne no regwen", 32'(RegWen), 32'd0);
    step();
    check("bne to fetch", {29'd0, state}, 32'd0);
    check("bne fetch en", {29'd0, RegWen, PCWen, iREN}, 32'd1);

    // ALU variety
    runAlu("ori", 32'h34220005, ALU_OR, 3'b010, 2'b01, 1'b0);
    runAlu("sll", 32'h00021080, ALU_SLL, 3'b100, 2'b00, 1'b0);
    runAlu("lui", 32'h3C011234, ALU_OR, 3'b011, 2'b01, 1'b0);
    runAlu("sub", 32'h00221822, ALU_SUB, 3'b000, 2'b00, 1'b1);
    runAlu("addi", 32'h20220005, ALU_ADD, 3'b001, 2'b01, 1'b1);
    runAlu("sltiu", 32'h2C220005, ALU_SLTU, 3'b001, 2'b01, 1'b0);
    runAlu("nor", 32'h00221827, ALU_NOR, 3'b000, 2'b00, 1'b0);

    // JAL
    fetchNow(c_jal);
    check("jal dec", {27'd0, jump_t, RegDst_t}, {27'd0, 3'b001, 2'b10});
    check("jal pctoreg", 32'(PcToReg), 32'd1);
    step();
    check("jal exec", {28'd0, state, PCWen}, {28'd0, 3'd2, 1'b0});
    step();
    check("jal wb", {27'd0, state, PCWen, PcToReg}, {27'd0, 3'd4, 1'b1, 1'b1});
    step();

    // SW aborted by reset during MEM
    fetchNow(c_sw);
    step();
    step();
    check("sw mem", {27'd0, state, dWEN, dREN}, {27'd0, 3'd3, 1'b1, 1'b0});
    step();
    check("sw mem hold", 32'(dWEN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("sw rst dwen", {30'd0, dWEN, dREN}, 32'd0);
    check("sw rst state", 32'(state), 32'd0);
    check("sw rst iren", {30'd0, iREN, RegWen}, 32'd0);
    #2 nRST = 1'b1;
    step();
    check("sw post rst", {28'd0, state, iREN}, {28'd0, 3'd0, 1'b1});

    // HALT opcode
    fetchNow(c_halt);
    step();
    check("halt state", 32'(state), 32'd5);
    check("halt flags", {30'd0, halt, fault}, 32'd2);
    Instr = c_add; ihit = 1'b1; dhit = 1'b1;
    step();
    step();
    ihit = 1'b0; dhit = 1'b0;
    check("halt absorbing", 32'(state), 32'd5);
    check("halt enables", {27'd0, iREN, RegWen, PCWen, dREN, dWEN}, 32'd0);

    // Illegal opcode
    nRST = 1'b0;
    #2;
    check("rst clears halt", {30'd0, halt, fault}, 32'd0);
    nRST = 1'b1;
    step();
    fetchNow(c_illeg);
    step();
    check("illegal state", 32'(state), 32'd5);
    check("illegal flags", {30'd0, halt, fault}, 32'd3);

    // Short timeout instance: no ihit -> fault after 4 FETCH cycles
    nRSTB = 1'b1;
    step();
    check("to iren", 32'(iRENB), 32'd1);
    step();
    step();
    step();
    check("to c4 still fetch", {29'd0, stateB}, 32'd0);
    check("to c4 no halt", 32'(haltB), 32'd0);
    step();
    check("to halt state", 32'(stateB), 32'd5);
    check("to flags", {30'd0, haltB, faultB}, 32'd3);

    // ihit on the fourth cycle wins over the timeout
    nRSTB = 1'b0;
    #2 nRSTB = 1'b1;
    step();
    step();
    step();
    step();
    InstrB = c_add; ihitB = 1'b1;
    step();
    ihitB = 1'b0;
    check("hit wins state", 32'(stateB), 32'd1);
    check("hit wins flags", {30'd0, haltB, faultB}, 32'd0);
    check("no-of checkOF", 32'(checkOFB), 32'd0);
    check("no-of aluop", 32'(ALUOPB), 32'(ALU_ADD));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL take parameter MEM_TIMEOUT, default 16: max wait cycles for ihit/dhit before fault; 0 disables the timeout.
REQ-002 SHALL take parameter CHECK_OF, default 1: 1 lets ADD/SUB/ADDI assert checkOF; 0 forces checkOF=0.
REQ-003 SHALL have port CLK, input, 1: single clock, rising edge.
REQ-004 SHALL have port nRST, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port Instr, input, 32: instruction word from imem, valid when ihit=1.
REQ-006 SHALL have ports ihit and dhit, input, 1 each: memory completion strobes.
REQ-007 SHALL have ports jump_t (3), RegDst_t (2), ALUSrc_t (3), ALUOP (aluop_t), output: datapath selects.
REQ-008 SHALL have ports RegWen, MemToReg, PcToReg, PCWen, iREN, dREN, dWEN, checkOF, output, 1 each.
REQ-009 SHALL have ports halt and fault, output, 1 each: sticky stop, and stop caused by timeout or illegal op.
REQ-010 SHALL have port state, output, 3: current state encoding.

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
REQ-012 FETCH SHALL assert iREN, latch Instr into internal IR on ihit, then go to DECODE.
REQ-013 DECODE SHALL last exactly 1 cycle; opcode 111111 -> HALT; illegal opcode/funct -> HALT with fault=1; otherwise -> EXEC.
REQ-014 From EXEC: LW/SW -> MEM; J/JR/BEQ/BNE -> FETCH with PCWen=1 that cycle; all others -> WB.
REQ-015 MEM SHALL hold dREN (LW) or dWEN (SW) until dhit; on dhit, LW -> WB and SW -> FETCH with PCWen=1.
REQ-016 WB SHALL assert RegWen and PCWen for exactly 1 cycle, then go to FETCH.
REQ-017 Selects SHALL decode combinationally from IR and be held stable from DECODE through the exit of WB.
REQ-018 RegWen, PCWen, iREN, dREN, dWEN SHALL be 0 outside the states named above.
REQ-019 jump_t SHALL be: 000 none, 001 J/JAL, 010 JR, 011 BEQ, 100 BNE.
REQ-020 RegDst_t SHALL be: 00 rd (R-type), 01 rt (I-type/LW), 10 r31 (JAL).
REQ-021 ALUSrc_t SHALL be: 000 reg, 001 sign-ext imm (ADDI/ADDIU/SLTI/SLTIU/LW/SW/BEQ/BNE), 010 zero-ext (ANDI/ORI/XORI), 011 imm<<16 (LUI), 100 shamt (SLL/SRL).
REQ-022 ALUOP SHALL map ADD/ADDU/ADDI/ADDIU/LW/SW -> ALU_ADD; SUB/SUBU/BEQ/BNE -> ALU_SUB; AND/ANDI -> ALU_AND; OR/ORI/LUI -> ALU_OR; XOR/XORI -> ALU_XOR; NOR -> ALU_NOR; SLT/SLTI -> ALU_SLT; SLTU/SLTIU -> ALU_SLTU; SLL -> ALU_SLL; SRL -> ALU_SRL.
REQ-023 JAL SHALL pass EXEC -> WB with PcToReg=1 and jump_t=001; PCWen SHALL be asserted in WB.
REQ-024 MemToReg SHALL be 1 only for LW.
REQ-025 checkOF SHALL be 1 only for ADD, SUB, ADDI, and only when CHECK_OF=1.
REQ-026 A wait counter SHALL clear on entry to FETCH/MEM and increment each cycle without a hit.
REQ-027 When the wait counter reaches MEM_TIMEOUT (MEM_TIMEOUT>0), the block SHALL go to HALT with fault=1.
REQ-028 A hit arriving on the cycle the counter reaches MEM_TIMEOUT SHALL win: normal transition, no fault.
REQ-029 ihit outside FETCH and dhit outside MEM SHALL be ignored.
REQ-030 HALT SHALL be absorbing: halt=1, all enables 0; only nRST exits it.

Reset
REQ-031 nRST=0 SHALL asynchronously force state=FETCH, IR=0, wait counter=0, halt=0, fault=0.
REQ-032 During reset SHALL drive RegWen=PCWen=dREN=dWEN=0 and iREN=0.
REQ-033 The first FETCH after nRST rises SHALL assert iREN on the next CLK edge.
REQ-034 Reset asserted mid-MEM SHALL abort the access: dREN/dWEN SHALL drop immediately and no write-back SHALL occur.

Verification
REQ-035 ADD (0x00221820), ihit after 2 cycles -> FETCH(3 cycles), DECODE, EXEC, WB: RegWen=1, RegDst_t=00, ALUOP=ALU_ADD, checkOF=1.
REQ-036 LW, dhit after 3 cycles -> MEM holds dREN=1 for 4 cycles, then WB with MemToReg=1, RegDst_t=01.
REQ-037 BNE -> EXEC asserts PCWen=1 with jump_t=100, no WB state, RegWen=0 throughout.
REQ-038 MEM_TIMEOUT=4, ihit never asserted -> halt=fault=1 after 4 FETCH cycles; ihit on the 4th cycle -> DECODE, fault=0.
REQ-039 Opcode 0x3F -> HALT with halt=1, fault=0; illegal opcode 0x3E -> halt=1, fault=1; a later ihit/dhit has no effect.
REQ-040 nRST pulsed low during SW MEM -> dWEN=0 asynchronously, state=0, iREN=1 after release.
